// File: rtl/depth_test_if.sv
// Fragment-in / pixel-out bundle between rasterizer, depth test stage and colour buffer.
interface depth_test_if #(
    parameter int unsigned FB_ADDR_WIDTH = 9,
    parameter int unsigned DEPTH_WIDTH   = 16,
    parameter int unsigned COLOR_WIDTH   = 4
);
    localparam int unsigned CNT_WIDTH = FB_ADDR_WIDTH + 1;

    logic                     frag_valid;
    logic [FB_ADDR_WIDTH-1:0] frag_addr;
    logic [DEPTH_WIDTH-1:0]   frag_depth;
    logic [COLOR_WIDTH-1:0]   frag_color;
    logic                     frag_ready;
    logic                     raster_done;
    logic                     clear_req;
    logic                     pix_we;
    logic [FB_ADDR_WIDTH-1:0] pix_addr;
    logic [COLOR_WIDTH-1:0]   pix_color;
    logic                     tile_done;
    logic [CNT_WIDTH-1:0]     pass_count;

    modport master (
        output frag_valid, frag_addr, frag_depth, frag_color, raster_done, clear_req,
        input  frag_ready, pix_we, pix_addr, pix_color, tile_done, pass_count
    );

    modport slave (
        input  frag_valid, frag_addr, frag_depth, frag_color, raster_done, clear_req,
        output frag_ready, pix_we, pix_addr, pix_color, tile_done, pass_count
    );
endinterface

// File: rtl/depth_test_unit.sv
// Per-tile z-buffer: depth-tests rasterized fragments against a local depth memory,
// commits passing fragments and forwards them as colour-buffer writes.
module depth_test_unit #(
    parameter int unsigned              FB_ADDR_WIDTH = 9,
    parameter int unsigned              FB_SIZE       = 512,
    parameter int unsigned              DEPTH_WIDTH   = 16,
    parameter int unsigned              COLOR_WIDTH   = 4,
    parameter logic [COLOR_WIDTH-1:0]   CLEAR_COLOR   = '0
) (
    input  logic          clk,
    input  logic          rst,
    depth_test_if.slave   bus
);
    localparam int unsigned CNT_WIDTH = FB_ADDR_WIDTH + 1;
    localparam logic [FB_ADDR_WIDTH-1:0] LAST_ADDR = FB_ADDR_WIDTH'(FB_SIZE - 1);

    typedef enum logic [1:0] {ST_CLEAR, ST_RUN, ST_DRAIN} state_e;

    state_e                   state_q, state_d;
    logic [FB_ADDR_WIDTH-1:0] clear_addr_q, clear_addr_d;

    logic                     s1_valid_q, s1_valid_d;
    logic [FB_ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
    logic [DEPTH_WIDTH-1:0]   s1_depth_q, s1_depth_d;
    logic [COLOR_WIDTH-1:0]   s1_color_q, s1_color_d;

    logic                     s2_valid_q, s2_valid_d;
    logic [FB_ADDR_WIDTH-1:0] s2_addr_q, s2_addr_d;
    logic [DEPTH_WIDTH-1:0]   s2_depth_q, s2_depth_d;
    logic [COLOR_WIDTH-1:0]   s2_color_q, s2_color_d;

    logic                     fwd_valid_q, fwd_valid_d;
    logic [FB_ADDR_WIDTH-1:0] fwd_addr_q, fwd_addr_d;
    logic [DEPTH_WIDTH-1:0]   fwd_depth_q, fwd_depth_d;

    logic                     pix_we_q, pix_we_d;
    logic [FB_ADDR_WIDTH-1:0] pix_addr_q, pix_addr_d;
    logic [COLOR_WIDTH-1:0]   pix_color_q, pix_color_d;
    logic                     frag_ready_q, frag_ready_d;
    logic                     tile_done_q, tile_done_d;
    logic [CNT_WIDTH-1:0]     pass_count_q, pass_count_d;

    logic [DEPTH_WIDTH-1:0]   mem [FB_SIZE];
    logic [DEPTH_WIDTH-1:0]   rd_data_q;

    logic                     accept_c;
    logic                     pass_c;
    logic [DEPTH_WIDTH-1:0]   stored_c;
    logic                     mem_we_c;
    logic [FB_ADDR_WIDTH-1:0] mem_waddr_c;
    logic [DEPTH_WIDTH-1:0]   mem_wdata_c;

    always_comb begin
        state_d      = state_q;
        clear_addr_d = clear_addr_q;
        pix_we_d     = 1'b0;
        pix_addr_d   = pix_addr_q;
        pix_color_d  = pix_color_q;
        pass_count_d = pass_count_q;
        mem_we_c     = 1'b0;
        mem_waddr_c  = s2_addr_q;
        mem_wdata_c  = s2_depth_q;

        accept_c   = frag_ready_q && bus.frag_valid;
        s1_valid_d = accept_c;
        s1_addr_d  = accept_c ? bus.frag_addr  : s1_addr_q;
        s1_depth_d = accept_c ? bus.frag_depth : s1_depth_q;
        s1_color_d = accept_c ? bus.frag_color : s1_color_q;

        s2_valid_d = s1_valid_q;
        s2_addr_d  = s1_addr_q;
        s2_depth_d = s1_depth_q;
        s2_color_d = s1_color_q;

        // The previous pass wrote memory on the same edge this fragment read it.
        stored_c = (fwd_valid_q && (fwd_addr_q == s2_addr_q)) ? fwd_depth_q : rd_data_q;
        pass_c   = s2_valid_q && (s2_depth_q < stored_c);

        fwd_valid_d = pass_c;
        fwd_addr_d  = s2_addr_q;
        fwd_depth_d = s2_depth_q;

        if (pass_c) begin
            mem_we_c    = 1'b1;
            pix_we_d    = 1'b1;
            pix_addr_d  = s2_addr_q;
            pix_color_d = s2_color_q;
            if (pass_count_q != '1) begin
                pass_count_d = pass_count_q + 1'b1;
            end
        end

        unique case (state_q)
            ST_CLEAR: begin
                mem_we_c    = 1'b1;
                mem_waddr_c = clear_addr_q;
                mem_wdata_c = '1;
                pix_we_d    = 1'b1;
                pix_addr_d  = clear_addr_q;
                pix_color_d = CLEAR_COLOR;
                if (clear_addr_q == LAST_ADDR) begin
                    state_d      = ST_RUN;
                    clear_addr_d = '0;
                    pass_count_d = '0;
                end else begin
                    clear_addr_d = clear_addr_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.clear_req) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // S2 retires on this edge, so only S1 has to be empty.
                if (!s1_valid_q) begin
                    state_d      = ST_CLEAR;
                    clear_addr_d = '0;
                end
            end
            default: state_d = ST_CLEAR;
        endcase

        frag_ready_d = (state_q == ST_RUN) && (state_d == ST_RUN);
        tile_done_d  = (state_q == ST_RUN) && (state_d == ST_RUN) &&
                       (tile_done_q ||
                        (bus.raster_done && !s1_valid_q && !s2_valid_q && !accept_c));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_CLEAR;
            clear_addr_q <= '0;
            s1_valid_q   <= 1'b0;
            s1_addr_q    <= '0;
            s1_depth_q   <= '0;
            s1_color_q   <= '0;
            s2_valid_q   <= 1'b0;
            s2_addr_q    <= '0;
            s2_depth_q   <= '0;
            s2_color_q   <= '0;
            fwd_valid_q  <= 1'b0;
            fwd_addr_q   <= '0;
            fwd_depth_q  <= '0;
            pix_we_q     <= 1'b0;
            pix_addr_q   <= '0;
            pix_color_q  <= '0;
            frag_ready_q <= 1'b0;
            tile_done_q  <= 1'b0;
            pass_count_q <= '0;
        end else begin
            state_q      <= state_d;
            clear_addr_q <= clear_addr_d;
            s1_valid_q   <= s1_valid_d;
            s1_addr_q    <= s1_addr_d;
            s1_depth_q   <= s1_depth_d;
            s1_color_q   <= s1_color_d;
            s2_valid_q   <= s2_valid_d;
            s2_addr_q    <= s2_addr_d;
            s2_depth_q   <= s2_depth_d;
            s2_color_q   <= s2_color_d;
            fwd_valid_q  <= fwd_valid_d;
            fwd_addr_q   <= fwd_addr_d;
            fwd_depth_q  <= fwd_depth_d;
            pix_we_q     <= pix_we_d;
            pix_addr_q   <= pix_addr_d;
            pix_color_q  <= pix_color_d;
            frag_ready_q <= frag_ready_d;
            tile_done_q  <= tile_done_d;
            pass_count_q <= pass_count_d;
        end
    end

    // Depth memory: one synchronous read port, one write port.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[mem_waddr_c] <= mem_wdata_c;
        end
        rd_data_q <= mem[s1_addr_q];
    end

    assign bus.frag_ready = frag_ready_q;
    assign bus.pix_we     = pix_we_q;
    assign bus.pix_addr   = pix_addr_q;
    assign bus.pix_color  = pix_color_q;
    assign bus.tile_done  = tile_done_q;
    assign bus.pass_count = pass_count_q;
endmodule

// File: tb/tb_depth_test_unit.sv
// Bench for depth_test_unit: directed scenarios plus a randomized fragment stream
// scored against an array-based z-buffer model.
module tb_depth_test_unit;
    localparam int unsigned AW = 9;
    localparam int unsigned SZ = 512;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 4;
    localparam int          PASS_MAX = 1023;

    logic clk;
    logic rst;

    int checks;
    int errors;
    int cyc;
    bit mon_en;

    logic [DW-1:0] ref_depth [SZ];
    int            ref_pass;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [CW-1:0] color;
    } exp_t;
    exp_t exp_q[$];

    depth_test_if #(.FB_ADDR_WIDTH(AW), .DEPTH_WIDTH(DW), .COLOR_WIDTH(CW)) bus ();

    depth_test_unit #(
        .FB_ADDR_WIDTH(AW), .FB_SIZE(SZ), .DEPTH_WIDTH(DW), .COLOR_WIDTH(CW), .CLEAR_COLOR('0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(SZ); i++) ref_depth[i] = '1;
        ref_pass = 0;
        exp_q.delete();
    endtask

    // Z-buffer rule: strictly nearer wins; a win shows up as a pixel write 3 ticks after driving.
    task automatic model_frag(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [CW-1:0] c);
        exp_t e;
        if (d < ref_depth[a]) begin
            ref_depth[a] = d;
            if (ref_pass < PASS_MAX) ref_pass++;
            e.cyc   = cyc + 3;
            e.addr  = a;
            e.color = c;
            exp_q.push_back(e);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                check("pix_write", 32'({bus.pix_we, bus.pix_addr, bus.pix_color}),
                      32'({1'b1, e.addr, e.color}));
            end else begin
                check("pix_idle", 32'(bus.pix_we), 32'(0));
            end
        end
    endtask

    task automatic send(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [CW-1:0] c);
        bus.frag_valid = v;
        bus.frag_addr  = a;
        bus.frag_depth = d;
        bus.frag_color = c;
        if (v && bus.frag_ready === 1'b1) model_frag(a, d, c);
        tick();
    endtask

    task automatic idle(input int n);
        bus.frag_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic check_clear(input bit first_seen);
        for (int i = 0; i < int'(SZ); i++) begin
            if (!(i == 0 && first_seen)) tick();
            check("clear_write", 32'({bus.pix_we, bus.frag_ready, bus.pix_addr, bus.pix_color}),
                  32'({1'b1, 1'b0, AW'(i), CW'(0)}));
        end
        tick();
        check("post_clear", 32'({bus.frag_ready, bus.pix_we, bus.pass_count}), 32'({1'b1, 1'b0, 10'd0}));
    endtask

    initial begin
        int n;
        int td_cyc;
        int last_pix;
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;

        checks = 0; errors = 0; cyc = 0; mon_en = 1'b0;
        rst = 1'b1;
        bus.frag_valid = 1'b0; bus.frag_addr = '0; bus.frag_depth = '0; bus.frag_color = '0;
        bus.raster_done = 1'b0; bus.clear_req = 1'b0;
        model_reset();

        // Reset state, then the automatic clear.
        repeat (3) tick();
        check("reset_outputs", 32'({bus.pix_we, bus.pix_addr, bus.pix_color, bus.frag_ready,
                                    bus.tile_done, bus.pass_count}), 32'(0));
        rst = 1'b0;
        check_clear(1'b0);
        mon_en = 1'b1;

        // Single fragment, then an equal-depth repeat.
        send(1'b1, AW'(5), DW'(100), CW'(3));
        idle(4);
        check("pc_single", 32'(bus.pass_count), 32'(1));
        send(1'b1, AW'(5), DW'(100), CW'(3));
        idle(4);
        check("pc_repeat", 32'(bus.pass_count), 32'(1));

        // Back-to-back same address exercises forwarding.
        send(1'b1, AW'(40), DW'(200), CW'(1));
        send(1'b1, AW'(40), DW'(150), CW'(2));
        send(1'b1, AW'(40), DW'(180), CW'(3));
        idle(4);
        check("pc_b2b", 32'(bus.pass_count), 32'(3));

        // Equal to the cleared value fails, one below passes.
        send(1'b1, AW'(77), DW'(16'hFFFF), CW'(5));
        idle(3);
        send(1'b1, AW'(77), DW'(16'hFFFE), CW'(6));
        idle(4);
        check("pc_boundary", 32'(bus.pass_count), 32'(4));

        // Random stream with frequent address reuse.
        ra = '0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) != 0) ra = AW'($urandom_range(0, 47));
            rd = ($urandom_range(0, 9) == 0) ? DW'(16'hFFFF) : DW'($urandom_range(0, 2000));
            send($urandom_range(0, 4) != 0, ra, rd, CW'($urandom_range(0, 15)));
        end
        idle(4);
        check("pc_random", 32'(bus.pass_count), 32'(ref_pass));

        // Enough passes to saturate the counter.
        for (int r = 0; r < 4; r++) begin
            for (int a = 100; a < 400; a++) begin
                send(1'b1, AW'(a), DW'(50000 - 1000 * r), CW'(a));
            end
        end
        idle(4);
        check("pc_saturate", 32'(bus.pass_count), 32'(PASS_MAX));
        check("pc_sat_model", 32'(bus.pass_count), 32'(ref_pass));

        // Ten fragments, then raster_done: tile_done within 2 cycles of the last pixel write.
        for (int i = 0; i < 10; i++) begin
            send(1'b1, AW'(400 + i), DW'($urandom_range(0, 60000)), CW'(i));
        end
        check("tile_done_pre", 32'(bus.tile_done), 32'(0));
        last_pix = (exp_q.size() > 0) ? exp_q[exp_q.size() - 1].cyc : cyc;
        bus.frag_valid  = 1'b0;
        bus.raster_done = 1'b1;
        td_cyc = -1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.tile_done === 1'b1 && td_cyc < 0) td_cyc = cyc;
        end
        check("tile_done_lat", 32'((td_cyc - last_pix >= 1) && (td_cyc - last_pix <= 2)), 32'(1));

        // clear_req drops tile_done, drains, then a full clear with fragments dropped.
        mon_en = 1'b0;
        bus.raster_done = 1'b0;
        bus.clear_req   = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        check("tile_done_cleared", 32'({bus.tile_done, bus.frag_ready}), 32'(0));
        bus.frag_valid = 1'b1; bus.frag_addr = AW'(400); bus.frag_depth = DW'(1); bus.frag_color = CW'(7);
        n = 0;
        while (bus.pix_we !== 1'b1 && n < 6) begin
            tick();
            n++;
        end
        check("drain_len", 32'(n <= 3), 32'(1));
        model_reset();
        check_clear(1'b1);
        bus.frag_valid = 1'b0;
        mon_en = 1'b1;
        send(1'b1, AW'(400), DW'(16'hFFFE), CW'(9));
        idle(4);
        check("pc_after_clear", 32'(bus.pass_count), 32'(1));

        // Asynchronous reset in the middle of a stream.
        send(1'b1, AW'(10), DW'(500), CW'(1));
        send(1'b1, AW'(11), DW'(500), CW'(2));
        send(1'b1, AW'(12), DW'(500), CW'(3));
        send(1'b1, AW'(13), DW'(500), CW'(4));
        #2;
        rst = 1'b1;
        bus.frag_valid = 1'b0;
        mon_en = 1'b0;
        #1;
        check("async_reset", 32'({bus.pix_we, bus.pix_addr, bus.pix_color, bus.frag_ready,
                                  bus.tile_done, bus.pass_count}), 32'(0));
        for (int i = 0; i < 2; i++) begin
            tick();
            check("reset_no_stale", 32'(bus.pix_we), 32'(0));
        end
        rst = 1'b0;
        model_reset();
        check_clear(1'b0);
        mon_en = 1'b1;
        send(1'b1, AW'(12), DW'(500), CW'(5));
        idle(4);
        check("pc_after_reset", 32'(bus.pass_count), 32'(1));
        check("exp_drained", 32'(exp_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/depth_test_unit.md
# depth_test_unit

Per-tile depth-test and z-buffer stage directly downstream of the rasterizer. It takes the rasterizer's fragment stream (address, write-enable, depth) plus a flat colour. It compares each fragment against a tile-local depth memory and commits passing fragments to depth memory. It also forwards them as pixel writes to the tile colour buffer. Depth memory is cleared automatically after reset and on request between triangles/tiles.

## Interface
Parameters:
- FB_ADDR_WIDTH, 9: tile pixel address width.
- FB_SIZE, 512: pixels per tile (32x16); addresses 0..FB_SIZE-1.
- DEPTH_WIDTH, 16: depth width, unsigned, smaller = nearer.
- COLOR_WIDTH, 4: colour index width.
- CLEAR_COLOR, 0: colour written during clear.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset; asynchronous and active-high.
- frag_valid  in  1  fragment present (rasterizer fb_write_enable).
- frag_addr  in  FB_ADDR_WIDTH  fragment pixel address.
- frag_depth  in  DEPTH_WIDTH  fragment depth.
- frag_color  in  COLOR_WIDTH  fragment colour.
- frag_ready  out  1  stage accepts fragments this cycle.
- raster_done  in  1  rasterizer finished, level.
- clear_req  in  1  request depth/colour clear, single-cycle pulse.
- pix_we  out  1  colour buffer write strobe.
- pix_addr  out  FB_ADDR_WIDTH  colour buffer write address.
- pix_color  out  COLOR_WIDTH  colour buffer write data.
- tile_done  out  1  all fragments of the tile resolved.
- pass_count  out  FB_ADDR_WIDTH+1  fragments passed since last clear, saturating.

## Operation
- Internal depth memory: FB_SIZE x DEPTH_WIDTH, synchronous read, one read and one write port.
- States:
  - CLEAR: walks clear_addr 0..FB_SIZE-1, one per cycle. Writes depth all-ones and pix_we=1, pix_addr=clear_addr, pix_color=CLEAR_COLOR. After FB_SIZE-1, goes to RUN and resets pass_count to 0.
  - RUN: frag_ready=1. A fragment is accepted when frag_valid=1.
  - DRAIN: entered on clear_req in RUN. frag_ready=0. Waits until the pipeline is empty, then goes to CLEAR with clear_addr=0.
- Pipeline:
  - S1 (accept cycle): register addr, depth, colour; issue depth read.
  - S2 (next cycle): compare. Pass iff frag_depth < stored depth, strictly less; equal depth fails.
  - On pass, at the end of S2: write depth memory, register pix_we=1 with the addr/colour, and increment pass_count (saturates at all-ones).
- Forwarding: if the S2 address equals the address written by the previous cycle's S2 pass, compare against that forwarded depth, not the memory read data.
- tile_done:
  - Set when raster_done=1 in RUN and no fragment is in S1/S2.
  - Cleared on clear_req, and held 0 in CLEAR and DRAIN.
- clear_req in CLEAR or DRAIN is ignored. frag_valid while frag_ready=0 is dropped and not counted.

## Timing
- Reset (async):
  - State → CLEAR, clear_addr=0.
  - pix_we=0, pix_addr=0, pix_color=0, frag_ready=0, tile_done=0, pass_count=0.
  - Pipeline valid bits cleared.
  - The first clear write appears the cycle after rst deasserts.
- Clear takes exactly FB_SIZE cycles. frag_ready rises the cycle after the last clear write.
- Latency: fragment accepted at edge N; the resulting pix_we is high during cycle N+2, for one cycle per passing fragment.
- Throughput: one fragment per cycle, no bubbles, including back-to-back fragments to the same address.
- DRAIN lasts at most 2 cycles, then CLEAR begins.
- tile_done asserts at most 2 cycles after raster_done, once the last fragment's pix_we has issued.
- Reset mid-clear or mid-run aborts immediately. In-flight fragments are lost; the clear restarts from 0.

## Test plan
- Reset then idle: pix_we high for exactly 512 cycles with addr 0..511 and colour 0; then frag_ready=1 and pass_count=0.
- Single fragment addr 5, depth 100, colour 3: pix_we at N+2 with addr 5, colour 3; pass_count=1. A repeat with depth 100 gives no pix_we.
- Back-to-back same address, depths 200 then 150 then 180 on consecutive cycles: first two pass, third fails via forwarding; pass_count=2.
- Depth 0xFFFF to a cleared pixel fails (equal). Depth 0xFFFE passes.
- Stream 10 fragments, then raster_done=1: tile_done rises within 2 cycles of the last pix_we. clear_req then drops tile_done, and a full 512-cycle clear runs with frag_ready=0.
- Assert rst during a fragment stream: outputs zero immediately, no stale pix_we, and the clear restarts at addr 0.
